// File: rtl/ysyx_22050612_wbu_if.sv
// Retire request channels into the writeback unit: ALU results and returning load data.
interface ysyx_22050612_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [2:0]            lsu_funct3;
    logic [2:0]            lsu_offset;
    logic [DATA_WIDTH-1:0] lsu_rdata;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_funct3, lsu_offset, lsu_rdata,
        input  alu_ready, lsu_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_funct3, lsu_offset, lsu_rdata,
        output alu_ready, lsu_ready
    );
endinterface

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: LSU-over-ALU arbitration, load extraction, one registered
// regfile write per cycle, and bypass of the pending write to decode.

module ysyx_22050612_wbu_lext #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            funct3,
    input  logic [2:0]            offset,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] val
);
    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        val = shifted;
        case (funct3)
            3'b000:  val = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  val = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b100:  val = {{(DATA_WIDTH-8){1'b0}},         shifted[7:0]};
            3'b101:  val = {{(DATA_WIDTH-16){1'b0}},        shifted[15:0]};
            3'b110:  val = {{(DATA_WIDTH-32){1'b0}},        shifted[31:0]};
            default: val = shifted;   // ld, and the unused 111 encoding
        endcase
    end
endmodule

module ysyx_22050612_wbu_fwd #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  vld,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [ADDR_WIDTH-1:0] rs,
    output logic                  hit
);
    // x0 never forwards: it reads as zero regardless of any pending write
    assign hit = vld && (rs == wb_rd) && (rs != '0);
endmodule

module ysyx_22050612_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050612_wbu_if.slave    req,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [63:0]           retire_cnt
);
    localparam int STAGES = 1;
    localparam int NUM_RD = 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    wb_req_t                          alu_req, lsu_req, sel_req, wb_q;
    logic                             accept;
    logic                             wb_vld_q;
    logic [STAGES:0]                  vld_pipe;
    logic [DATA_WIDTH-1:0]            load_val;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rs_vec;
    logic [NUM_RD-1:0]                hit_vec;

    assign req.lsu_ready = !rst;
    assign req.alu_ready = !rst && !req.lsu_valid;

    ysyx_22050612_wbu_lext #(.DATA_WIDTH(DATA_WIDTH)) u_lext (
        .funct3 (req.lsu_funct3),
        .offset (req.lsu_offset),
        .rdata  (req.lsu_rdata),
        .val    (load_val)
    );

    assign alu_req = '{rd: req.alu_rd, data: req.alu_data};
    assign lsu_req = '{rd: req.lsu_rd, data: load_val};
    assign sel_req = req.lsu_valid ? lsu_req : alu_req;
    assign accept  = req.lsu_valid || (req.alu_valid && req.alu_ready);

    // stage 0 is the accept strobe, stage STAGES is the pending regfile write
    always_comb begin
        vld_pipe         = '0;
        vld_pipe[0]      = accept;
        vld_pipe[STAGES] = wb_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld_q   <= 1'b0;
            wb_q       <= '0;
            retire_cnt <= '0;
        end else begin
            wb_vld_q <= vld_pipe[STAGES-1];
            if (accept) begin
                wb_q       <= sel_req;
                retire_cnt <= retire_cnt + 64'd1;
            end
        end
    end

    assign wen      = vld_pipe[STAGES] && (wb_q.rd != '0);
    assign waddr    = wb_q.rd;
    assign wdata    = wb_q.data;
    assign fwd_data = wb_q.data;

    assign rs_vec = {rs2, rs1};

    for (genvar i = 0; i < NUM_RD; i++) begin : g_fwd
        ysyx_22050612_wbu_fwd #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd (
            .vld   (vld_pipe[STAGES]),
            .wb_rd (wb_q.rd),
            .rs    (rs_vec[i]),
            .hit   (hit_vec[i])
        );
    end

    assign fwd1_hit = hit_vec[0];
    assign fwd2_hit = hit_vec[1];
endmodule
